// File: rtl/counter_capture_if.sv
// Valid/ready stream carrying captured counter values from counter_capture
// to its consumer.
interface counter_capture_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] out_data_o;
    logic             out_valid_o;
    logic             out_ready_i;

    modport master (
        output out_data_o,
        output out_valid_o,
        input  out_ready_i
    );

    modport slave (
        input  out_data_o,
        input  out_valid_o,
        output out_ready_i
    );
endinterface

// File: rtl/counter_capture.sv
// Snapshots the upstream counter on each rising edge of evt_i into a small FIFO.
// Define COUNTER_CAPTURE_DELTA_EN to store the interval since the previous event instead.
module counter_capture #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         cnt_i,
    input  logic                     evt_i,
    counter_capture_if.master        out_bus,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     overflow_o,
    input  logic                     ovf_clr_i
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      level_reg;
    logic             evt_q_reg;
    logic             overflow_reg;

    logic             edge_det;
    logic             full;
    logic             pop;
    logic             push;
    logic             drop;
    logic [WIDTH-1:0] wr_data;

    assign edge_det = evt_i & ~evt_q_reg;
    assign full     = (level_reg == FULL_LEVEL);
    assign pop      = (level_reg != '0) & out_bus.out_ready_i;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the edge.
    assign push     = edge_det & (~full | pop);
    assign drop     = edge_det & full & ~pop;

`ifdef COUNTER_CAPTURE_DELTA_EN
    logic [WIDTH-1:0] last_cnt_reg;

    // Updated on dropped edges too, so the next delta spans from the real previous event.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_cnt_reg <= '0;
        end else if (edge_det) begin
            last_cnt_reg <= cnt_i;
        end
    end

    assign wr_data = cnt_i - last_cnt_reg;
`else
    assign wr_data = cnt_i;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
        end else if (push) begin
            mem_reg[wr_ptr_reg] <= wr_data;
        end
    end

    // evt_q resets high so a strobe already asserted at reset release is not an edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            level_reg    <= '0;
            evt_q_reg    <= 1'b1;
            overflow_reg <= 1'b0;
        end else begin
            evt_q_reg <= evt_i;
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            if (push && !pop) begin
                level_reg <= level_reg + (AW + 1)'(1);
            end else if (pop && !push) begin
                level_reg <= level_reg - (AW + 1)'(1);
            end
            if (drop) begin
                overflow_reg <= 1'b1;
            end else if (ovf_clr_i) begin
                overflow_reg <= 1'b0;
            end
        end
    end

    assign out_bus.out_data_o  = mem_reg[rd_ptr_reg];
    assign out_bus.out_valid_o = (level_reg != '0);
    assign level_o             = level_reg;
    assign overflow_o          = overflow_reg;

endmodule

// File: tb/tb_counter_capture.sv
// Scoreboard bench for counter_capture: expected captures are queued when an edge
// is driven and compared as the consumer pops them.
module tb_counter_capture;
    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             reset;
    logic [WIDTH-1:0] cnt_i;
    logic             evt_i;
    logic             ovf_clr_i;
    logic [LW-1:0]    level_o;
    logic             overflow_o;

    counter_capture_if #(.WIDTH(WIDTH)) bus ();

    counter_capture #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .cnt_i      (cnt_i),
        .evt_i      (evt_i),
        .out_bus    (bus),
        .level_o    (level_o),
        .overflow_o (overflow_o),
        .ovf_clr_i  (ovf_clr_i)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [WIDTH-1:0] sb [$];
    logic             m_evt_q;
    logic             m_ovf;
    logic [WIDTH-1:0] m_last;

`ifdef COUNTER_CAPTURE_DELTA_EN
    localparam bit DELTA = 1'b1;
`else
    localparam bit DELTA = 1'b0;
`endif

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Called at a falling edge: drive one cycle of inputs, check, update model.
    task automatic tick(input logic evt, input logic [WIDTH-1:0] cnt,
                        input logic rdy, input logic clr);
        logic edge_m, full_m, pop_m;
        evt_i = evt;
        cnt_i = cnt;
        bus.out_ready_i = rdy;
        ovf_clr_i = clr;
        #1;
        chk("level", 32'(level_o), 32'(sb.size()));
        chk("overflow", 32'(overflow_o), 32'(m_ovf));
        chk("valid", 32'(bus.out_valid_o), 32'(sb.size() != 0));
        if (sb.size() != 0) chk("data", 32'(bus.out_data_o), 32'(sb[0]));
        edge_m = evt & ~m_evt_q;
        full_m = (sb.size() == DEPTH);
        pop_m  = rdy && (sb.size() != 0);
        if (pop_m) begin
            $display("pop  data=%02h level=%0d", sb[0], sb.size());
            void'(sb.pop_front());
        end
        if (edge_m && (!full_m || pop_m)) begin
            sb.push_back(cnt - m_last);
            $display("push cnt=%02h exp=%02h", cnt, cnt - m_last);
        end else if (edge_m) begin
            $display("drop cnt=%02h", cnt);
        end
        if (edge_m && full_m && !pop_m) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        if (edge_m && DELTA) m_last = cnt;
        m_evt_q = evt;
        @(negedge clk);
    endtask

    task automatic ev(input logic [WIDTH-1:0] cnt, input logic rdy);
        tick(1'b1, cnt, rdy, 1'b0);
        tick(1'b0, cnt, rdy, 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 1 && sb.size() != 0; i++) tick(1'b0, '0, 1'b1, 1'b0);
        tick(1'b0, '0, 1'b0, 1'b0);
    endtask

    // Asserts reset between clock edges with the strobe held high.
    task automatic do_reset();
        evt_i = 1'b1;
        cnt_i = '0;
        bus.out_ready_i = 1'b0;
        ovf_clr_i = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("rst_valid", 32'(bus.out_valid_o), 32'd0);
        chk("rst_level", 32'(level_o), 32'd0);
        chk("rst_ovf", 32'(overflow_o), 32'd0);
        chk("rst_data", 32'(bus.out_data_o), 32'd0);
        sb.delete();
        m_evt_q = 1'b1;
        m_ovf   = 1'b0;
        m_last  = '0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        logic [WIDTH-1:0] delta_cnt [4];
        logic [WIDTH-1:0] delta_exp [4];
        reset = 1'b0;
        evt_i = 1'b1;
        cnt_i = '0;
        ovf_clr_i = 1'b0;
        bus.out_ready_i = 1'b0;
        @(negedge clk);
        do_reset();

        // Held-high strobe across reset, then a single capture
        tick(1'b1, 8'h11, 1'b0, 1'b0);
        tick(1'b1, 8'h12, 1'b0, 1'b0);
        tick(1'b0, 8'h20, 1'b0, 1'b0);
        tick(1'b1, 8'h25, 1'b0, 1'b0);
        chk("t1_data", 32'(bus.out_data_o), 32'h25);
        chk("t1_level", 32'(level_o), 32'd1);
        tick(1'b1, 8'h26, 1'b0, 1'b0);
        drain();

        // Ordering and hold
        ev(8'h10, 1'b0);
        ev(8'h11, 1'b0);
        ev(8'h30, 1'b0);
        chk("t2_level", 32'(level_o), 32'd3);
        drain();

        // Overflow, clear, and drop-with-clear
        for (int i = 1; i <= 5; i++) ev(WIDTH'(i), 1'b0);
        chk("t3_level", 32'(level_o), 32'd4);
        chk("t3_ovf", 32'(overflow_o), 32'd1);
        tick(1'b0, '0, 1'b0, 1'b1);
        chk("t3_clr", 32'(overflow_o), 32'd0);
        tick(1'b1, 8'h06, 1'b0, 1'b1);
        chk("t3_setwins", 32'(overflow_o), 32'd1);
        tick(1'b0, '0, 1'b0, 1'b0);
        drain();
        tick(1'b0, '0, 1'b0, 1'b1);

        // Push and pop together at full
        for (int i = 1; i <= 4; i++) ev(WIDTH'(8'h70 + i), 1'b0);
        tick(1'b1, 8'h77, 1'b1, 1'b0);
        chk("t4_level", 32'(level_o), 32'd4);
        chk("t4_ovf", 32'(overflow_o), 32'd0);
        tick(1'b0, '0, 1'b0, 1'b0);
        drain();

        // Reset while entries are queued
        ev(8'h50, 1'b0);
        ev(8'h51, 1'b0);
        do_reset();
        tick(1'b1, 8'h52, 1'b0, 1'b0);
        tick(1'b0, 8'h53, 1'b0, 1'b0);

        // Pointer wrap with interleaved pops
        ev(8'h80, 1'b0);
        ev(8'h81, 1'b0);
        for (int i = 0; i < 20; i++) begin
            tick(1'b1, WIDTH'(8'h90 + i), 1'b0, 1'b0);
            tick(1'b0, '0, 1'b1, 1'b0);
        end
        drain();

        if (DELTA) begin
            delta_cnt = '{8'h05, 8'h0C, 8'hFE, 8'h03};
            delta_exp = '{8'h05, 8'h07, 8'hF2, 8'h05};
            do_reset();
            tick(1'b0, '0, 1'b0, 1'b0);
            for (int k = 0; k < 4; k++) ev(delta_cnt[k], 1'b0);
            for (int k = 0; k < 4; k++) begin
                chk("t6_delta", 32'(bus.out_data_o), 32'(delta_exp[k]));
                tick(1'b0, '0, 1'b1, 1'b0);
            end
            tick(1'b0, '0, 1'b0, 1'b0);
        end

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/counter_capture.md
Name: counter_capture

Overview:
- Sits directly downstream of the free-running event counter and consumes its count output.
- On each rising edge of an event strobe, it snapshots the count value and pushes it into a small FIFO.
- A consumer drains the FIFO over a valid/ready interface.
- Used for timestamping external events against the counter timebase.

Parameters:
WIDTH, 8, width of the count input and of each captured entry; must match the upstream counter WIDTH.
DEPTH, 4, number of FIFO entries; power of two, minimum 2.

Ports:
clk  input  1  clock; all logic is on the rising edge.
reset  input  1  asynchronous, active-high reset.
cnt_i  input  WIDTH  count value from the upstream counter.
evt_i  input  1  event strobe; synchronous to clk.
out_data_o  output  WIDTH  captured value at the FIFO head.
out_valid_o  output  1  FIFO non-empty; out_data_o is valid.
out_ready_i  input  1  consumer accepts the head entry when asserted together with out_valid_o.
level_o  output  log2(DEPTH)+1  current FIFO occupancy, 0..DEPTH.
overflow_o  output  1  sticky flag: an event was dropped because the FIFO was full.
ovf_clr_i  input  1  synchronous clear of overflow_o.

Behaviour:
- Clocking and reset: one clock (clk). Reset is asynchronous and active-high on port reset. Every register clears on posedge reset regardless of clk.
- Reset values:
  - out_valid_o = 0, level_o = 0, overflow_o = 0.
  - out_data_o = 0; it holds the head storage word, which is 0 when empty after reset.
  - Read and write pointers = 0.
  - Event history register evt_q = 1, so an evt_i held high across reset release does not produce a capture.
- Edge detect:
  - evt_q <= evt_i every cycle.
  - edge = evt_i & ~evt_q.
  - Only a 0->1 transition produces a capture; a held-high evt_i produces exactly one capture.
- Capture: on a cycle with edge = 1, the cnt_i value sampled in that same cycle is the value written.
- Push and pop:
  - push = edge & (not full, or pop in the same cycle).
  - pop = out_valid_o & out_ready_i.
- Latency: the entry is visible on out_data_o/out_valid_o in the cycle after the edge cycle when the FIFO was empty. There is no combinational bypass.
- FIFO ordering: strict FIFO. Pointers are log2(DEPTH) bits and wrap modulo DEPTH. level_o tracks occupancy: +1 on push only, -1 on pop only, unchanged on both or neither.
- Full (level_o = DEPTH):
  - edge without pop: entry is dropped, FIFO contents unchanged, overflow_o <= 1.
  - edge with pop in the same cycle: push accepted, level_o stays DEPTH, overflow_o not set.
- Empty (level_o = 0): out_ready_i is ignored and pointers do not move. An edge while empty pushes normally.
- Overflow flag:
  - Stays set until ovf_clr_i = 1.
  - If a drop and ovf_clr_i occur in the same cycle, set wins and overflow_o remains 1.
- out_data_o must not change while out_valid_o = 1 and out_ready_i = 0.
- Reset mid-operation: all queued entries are discarded immediately. The asynchronous assertion forces out_valid_o = 0 within the same cycle.

Optional Feature:
- Macro: COUNTER_CAPTURE_DELTA_EN.
- Defined:
  - Adds a WIDTH-bit last_cnt register, reset 0.
  - The value written is (cnt_i - last_cnt) mod 2^WIDTH, so counter wrap-around yields the correct modular interval.
  - last_cnt <= cnt_i on every detected edge, including dropped ones, so deltas always measure from the previous real event.
  - The first capture after reset therefore equals the raw cnt_i.
- Undefined: the raw cnt_i is written, and no last_cnt register exists.

Test Plan:
1. Reset and basic capture: hold evt_i=1 through reset release -> no capture, level_o=0. Then evt_i 0->1 with cnt_i=0x25 and out_ready_i=0 -> next cycle out_valid_o=1, out_data_o=0x25, level_o=1.
2. Ordering and hold: edges at cnt_i=0x10, 0x11, 0x30 with out_ready_i=0 -> level_o=3 and out_data_o held at 0x10. Then out_ready_i=1 for 3 cycles -> 0x10, 0x11, 0x30 in order, then out_valid_o=0.
3. Overflow: DEPTH=4 and out_ready_i=0; 5 edges at cnt_i=1..5 -> level_o=4, overflow_o=1, drained data 1, 2, 3, 4. ovf_clr_i pulse -> overflow_o=0. Drop and clear in the same cycle -> overflow_o stays 1.
4. Simultaneous push and pop at full: level_o=4, out_ready_i=1, edge at cnt_i=0x77 -> level_o stays 4, overflow_o=0, and 0x77 is the last entry drained.
5. Pointer wrap: 20 edges interleaved with pops, keeping level_o between 1 and 3 -> every value emerges in order with no loss across multiple pointer wraps.
6. Delta mode (COUNTER_CAPTURE_DELTA_EN): edges at cnt_i=0x05, 0x0C, 0xFE, 0x03 (WIDTH=8) -> outputs 0x05, 0x07, 0xF2, 0x05.
